// File: rtl/hdmi_pixel_unpacker_pkg.sv
// Shared types and elaboration helpers for the HDMI pixel unpacker.
package hdmi_pixel_unpacker_pkg;

  // Output-arming state: IDLE waits for a prefilled sof, ACTIVE serves de.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Width of a bit pointer/level that must represent 0..total inclusive.
  function automatic int ptr_w(input int total);
    return $clog2(total + 1);
  endfunction

  // Width of a word index 0..n-1 (never less than one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hdmi_pixel_ring.sv
// Circular word store with a G-bit read window addressed in bits.
// Storage is unreset on purpose: the pointers in the top level decide
// which bits are meaningful.
module hdmi_pixel_ring
  import hdmi_pixel_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BUF_WORDS  = 6,
  parameter int G          = 24,
  localparam int TOTAL     = BUF_WORDS * DATA_WIDTH,
  localparam int LW        = ptr_w(TOTAL),
  localparam int IW        = idx_w(BUF_WORDS)
) (
  input  logic                  aclk,
  input  logic                  we,
  input  logic [IW-1:0]         wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [LW-1:0]         rd_bit,
  output logic [G-1:0]          window
);

  logic [BUF_WORDS-1:0][DATA_WIDTH-1:0] mem;
  logic [TOTAL-1:0]                     flat;

  // Word write port; word k sits at bits [k*DATA_WIDTH +: DATA_WIDTH].
  always_ff @(posedge aclk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  // rd_bit only takes multiples of G below TOTAL and TOTAL % G == 0, so the
  // window may straddle two words but never the end of the store.
  assign flat   = mem;
  assign window = flat[rd_bit +: G];

endmodule

// File: rtl/hdmi_pixel_unpacker.sv
// AXI-Stream word to pixel-group width converter for the HDMI path.
// Buffers DMA words, arms on a prefilled sof, serves one group per de,
// flushes and re-arms on underflow.
module hdmi_pixel_unpacker
  import hdmi_pixel_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int PIXEL_WIDTH    = 24,
  parameter int PIXELS_PER_CLK = 1,
  parameter int BUF_WORDS      = 6,
  parameter int PREFILL_WORDS  = 6,
  localparam int G             = PIXEL_WIDTH * PIXELS_PER_CLK
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  sof,
  input  logic                  de,
  output logic [G-1:0]          pix_data,
  output logic                  pix_valid,
  output logic                  synced,
  output logic                  underflow,
  output logic                  sof_missed,
  output logic [15:0]           underflow_count
);

  localparam int TOTAL = BUF_WORDS * DATA_WIDTH;
  localparam int LW    = ptr_w(TOTAL);
  localparam int IW    = idx_w(BUF_WORDS);

  localparam logic [LW-1:0] TOTAL_L   = LW'(TOTAL);
  localparam logic [LW-1:0] DW_L      = LW'(DATA_WIDTH);
  localparam logic [LW-1:0] G_L       = LW'(G);
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL_WORDS * DATA_WIDTH);
  localparam logic [LW-1:0] RD_LAST   = LW'(TOTAL - G);
  localparam logic [IW-1:0] WR_LAST   = IW'(BUF_WORDS - 1);

  // Elaboration guards on the parameter set.
  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (TOTAL % G != 0) begin : g_bad_total
    $error("BUF_WORDS*DATA_WIDTH must be a multiple of PIXEL_WIDTH*PIXELS_PER_CLK");
  end
  if (PREFILL_WORDS < 1 || PREFILL_WORDS > BUF_WORDS) begin : g_bad_prefill
    $error("PREFILL_WORDS must lie in 1..BUF_WORDS");
  end

  state_t          state;
  logic [IW-1:0]   wr_idx;
  logic            wr_wrap;
  logic [LW-1:0]   rd_bit;
  logic            rd_wrap;
  logic [LW-1:0]   wr_base;
  logic [LW-1:0]   level_bits;
  logic [G-1:0]    window;
  logic            wr_fire;
  logic            unused_tlast;

  // Line structure comes from the timing generator, not from the stream.
  assign unused_tlast = s_axis_tlast;

  // Fill level in bits; modular arithmetic is exact because 0..TOTAL fits LW.
  assign wr_base    = LW'(wr_idx) * DW_L;
  assign level_bits = wr_base - rd_bit + ((wr_wrap != rd_wrap) ? TOTAL_L : '0);

  // Ready depends on registers only: no credit for a same-cycle read.
  assign s_axis_tready = (TOTAL_L - level_bits) >= DW_L;
  assign wr_fire       = s_axis_tvalid && s_axis_tready;
  assign synced        = (state == ST_ACTIVE);

  hdmi_pixel_ring #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_WORDS  (BUF_WORDS),
    .G          (G)
  ) u_ring (
    .aclk    (aclk),
    .we      (wr_fire),
    .wr_idx  (wr_idx),
    .wr_data (s_axis_tdata),
    .rd_bit  (rd_bit),
    .window  (window)
  );

  // Pointers, arming FSM and registered status; a flush overrides any write
  // advance in the same cycle, discarding that word.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= ST_IDLE;
      wr_idx          <= '0;
      wr_wrap         <= 1'b0;
      rd_bit          <= '0;
      rd_wrap         <= 1'b0;
      pix_data        <= '0;
      pix_valid       <= 1'b0;
      underflow       <= 1'b0;
      sof_missed      <= 1'b0;
      underflow_count <= '0;
    end else begin
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      underflow  <= 1'b0;
      sof_missed <= 1'b0;

      if (wr_fire) begin
        if (wr_idx == WR_LAST) begin
          wr_idx  <= '0;
          wr_wrap <= ~wr_wrap;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (sof) begin
            if (level_bits >= PREFILL_L) state <= ST_ACTIVE;
            else                         sof_missed <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (de) begin
            if (level_bits >= G_L) begin
              pix_data  <= window;
              pix_valid <= 1'b1;
              if (rd_bit == RD_LAST) begin
                rd_bit  <= '0;
                rd_wrap <= ~rd_wrap;
              end else begin
                rd_bit <= rd_bit + G_L;
              end
            end else begin
              underflow <= 1'b1;
              if (underflow_count != 16'hFFFF)
                underflow_count <= underflow_count + 16'd1;
              wr_idx  <= '0;
              wr_wrap <= 1'b0;
              rd_bit  <= '0;
              rd_wrap <= 1'b0;
              state   <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_pixel_unpacker.sv
// Bench for hdmi_pixel_unpacker: directed scenarios plus random traffic on
// the default configuration against a bit-queue model, and a rate-matched
// run on a two-pixel, 32-bit configuration against a word scoreboard.
module tb_hdmi_pixel_unpacker;

  localparam int DW      = 64;
  localparam int GW      = 24;
  localparam int TOT     = 384;
  localparam int PREFILL = 6;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;

  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0, sof = 1'b0, de = 1'b0, tready;
  logic [23:0] pix_data;
  logic        pix_valid, synced, underflow, sof_missed;
  logic [15:0] ucount;

  logic [63:0] tdata2 = '0;
  logic        tvalid2 = 1'b0, sof2 = 1'b0, de2 = 1'b0, tready2;
  logic [63:0] pix_data2;
  logic        pix_valid2, synced2, underflow2, sof_missed2;
  logic [15:0] ucount2;

  int n_chk = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  hdmi_pixel_unpacker dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(1'b0),
    .s_axis_tready(tready), .sof(sof), .de(de),
    .pix_data(pix_data), .pix_valid(pix_valid), .synced(synced),
    .underflow(underflow), .sof_missed(sof_missed), .underflow_count(ucount)
  );

  hdmi_pixel_unpacker #(
    .DATA_WIDTH(64), .PIXEL_WIDTH(32), .PIXELS_PER_CLK(2),
    .BUF_WORDS(4), .PREFILL_WORDS(4)
  ) dut2 (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(tdata2), .s_axis_tvalid(tvalid2), .s_axis_tlast(1'b0),
    .s_axis_tready(tready2), .sof(sof2), .de(de2),
    .pix_data(pix_data2), .pix_valid(pix_valid2), .synced(synced2),
    .underflow(underflow2), .sof_missed(sof_missed2), .underflow_count(ucount2)
  );

  // Reference model: buffered stream as a queue of bits, oldest first.
  bit m_q[$];
  bit m_active;
  int m_ucnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] seq_word(input int n);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'((8*n + b) & 8'hFF);
    return w;
  endfunction

  // One clock of the default DUT: drive, predict from the model, compare.
  task automatic step(input bit v, input logic [63:0] d, input bit s, input bit e);
    int          lvl;
    bit          acc, e_uf, e_miss, e_vld;
    logic [23:0] e_pix;
    @(negedge aclk);
    tvalid = v; tdata = d; sof = s; de = e;
    lvl = m_q.size();
    acc = v && (TOT - lvl >= DW);
    chk("tready", tready, logic'(TOT - lvl >= DW));
    e_uf = 0; e_miss = 0; e_vld = 0; e_pix = '0;
    if (!m_active) begin
      if (s) begin
        if (lvl >= PREFILL*DW) m_active = 1;
        else                   e_miss = 1;
      end
    end else if (e) begin
      if (lvl >= GW) begin
        for (int k = 0; k < GW; k++) e_pix[k] = m_q.pop_front();
        e_vld = 1;
      end else begin
        e_uf = 1;
        if (m_ucnt < 16'hFFFF) m_ucnt++;
        m_active = 0;
        m_q.delete();
      end
    end
    if (acc && !e_uf)
      for (int k = 0; k < DW; k++) m_q.push_back(d[k]);
    @(posedge aclk); #1;
    chk("pix_data", pix_data, e_pix);
    chk("pix_valid", pix_valid, e_vld);
    chk("underflow", underflow, e_uf);
    chk("sof_missed", sof_missed, e_miss);
    chk("synced", synced, m_active);
    chk("underflow_count", ucount, m_ucnt);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1; tvalid = 0; sof = 0; de = 0; tvalid2 = 0; sof2 = 0; de2 = 0;
    @(posedge aclk); #1;
    m_q.delete(); m_active = 0; m_ucnt = 0;
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_synced", synced, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_sof_missed", sof_missed, 0);
    chk("rst_ucount", ucount, 0);
    chk("rst_tready", tready, 1);
    chk("rst_tready2", tready2, 1);
    @(negedge aclk);
    areset = 0;
  endtask

  logic [23:0] exp_first [4];
  logic [63:0] sb2 [$];

  initial begin
    exp_first[0] = 24'h020100; exp_first[1] = 24'h050403;
    exp_first[2] = 24'h080706; exp_first[3] = 24'h0B0A09;
    m_active = 0; m_ucnt = 0;
    repeat (2) @(posedge aclk);
    do_reset();

    // Prefill, sof, continuous de: first groups are fixed byte triples.
    for (int i = 0; i < 6; i++) step(1, seq_word(i), 0, 0);
    step(0, '0, 1, 0);
    chk("armed_synced", synced, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 0, 1);
      chk("first_pix", pix_data, exp_first[i]);
    end
    // Drain the rest of the 16 groups, then the 17th de underflows.
    for (int i = 4; i < 16; i++) step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    chk("uf_pulse", underflow, 1);
    chk("uf_pix_valid", pix_valid, 0);
    chk("uf_count", ucount, 1);
    chk("uf_synced", synced, 0);
    chk("uf_tready", tready, 1);

    // Fill with no sof: exactly six words fit.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, {$urandom, $urandom}, 0, 0);
    chk("full_tready", tready, 0);
    step(1, {$urandom, $urandom}, 0, 0);
    step(1, {$urandom, $urandom}, 0, 0);

    // sof before prefill is reported and ignored; a later sof arms.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, seq_word(i), 0, 0);
    step(0, '0, 1, 1);
    chk("miss_pulse", sof_missed, 1);
    chk("miss_synced", synced, 0);
    chk("miss_pix", pix_data, 0);
    step(0, '0, 0, 0);
    chk("miss_once", sof_missed, 0);
    for (int i = 3; i < 6; i++) step(1, seq_word(i), 0, 0);
    step(0, '0, 1, 0);
    chk("rearm_synced", synced, 1);
    for (int i = 0; i < 3; i++) step(1, seq_word(6 + i), 0, 1);

    // Reset while ACTIVE.
    do_reset();

    // Random traffic: a write-heavy phase then a read-heavy phase.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) < 60, {$urandom, $urandom},
           $urandom_range(0, 29) == 0, $urandom_range(0, 99) < 50);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) < 30, {$urandom, $urandom},
           $urandom_range(0, 19) == 0, $urandom_range(0, 99) < 90);

    // Two 32-bit pixels per beat: each group is one whole word.
    do_reset();
    begin
      int  wcnt;
      bit  acc;
      wcnt = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge aclk);
        tvalid2 = 1; tdata2 = seq_word(wcnt);
        if (tready2) begin sb2.push_back(seq_word(wcnt)); wcnt++; end
      end
      @(negedge aclk);
      tvalid2 = 0; sof2 = 1;
      @(posedge aclk); #1;
      chk("p2_synced", synced2, 1);
      for (int i = 0; i < 1000; i++) begin
        @(negedge aclk);
        sof2 = 0; de2 = 1; tvalid2 = 1; tdata2 = seq_word(wcnt);
        acc = tready2;
        if (i >= 1) chk("p2_tready", tready2, 1);
        @(posedge aclk); #1;
        chk("p2_pix_valid", pix_valid2, 1);
        chk("p2_pix_data", pix_data2, sb2.pop_front());
        chk("p2_underflow", underflow2, 0);
        if (i == 0) chk("p2_first_word", pix_data2, 64'h0706050403020100);
        if (acc) begin sb2.push_back(seq_word(wcnt)); wcnt++; end
      end
      chk("p2_ucount", ucount2, 0);
      @(negedge aclk);
      de2 = 0; tvalid2 = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
